// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning the HI/LO pair: WIDTH-cycle shift-add multiply
// and restoring divide, with sign fix-up in a final cycle and direct mthi/mtlo writes.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rmd;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture: signed ops (op[0]==0) run on magnitudes, signs fixed up in S_FIX.
    always_comb begin
        w_signed = ~op[0];
        w_a_neg  = w_signed & src_a[WIDTH-1];
        w_b_neg  = w_signed & src_b[WIDTH-1];
        w_a_mag  = w_a_neg ? -src_a : src_a;
        w_b_mag  = w_b_neg ? -src_b : src_b;
    end

    // Multiply step: add into the upper half, shift the accumulator right one bit.
    // Divide step: acc holds {remainder, quotient}; dividend bits stream out of r_a's MSB.
    always_comb begin
        w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};
        w_mul_next = {w_madd, r_acc[WIDTH-1:1]};
        w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_b});
        w_sub      = w_shift[WIDTH-1:0] - r_b;
        w_rem      = w_ge ? w_sub : w_shift[WIDTH-1:0];
        w_div_next = {w_rem, r_acc[WIDTH-2:0], w_ge};
        w_prod     = r_neg_q ? -r_acc : r_acc;
        w_quo      = r_div0 ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
        w_rmd      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg & op[1];
                        r_div0   <= op[1] & (src_b == '0);
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_div_next;
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b >> 1;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rmd;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random operations checked against a 64-bit
// arithmetic reference model, plus busy-window, direct-write and reset scenarios.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic        busy, done;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_done(output int cyc, output bit moved, output bit busy_ok);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo; cyc = 0; moved = 1'b0; busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (done !== 1'b1) begin
                if (hi !== h0 || lo !== l0) moved = 1'b1;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end while (done !== 1'b1 && cyc < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL reset_hilo: got %h/%h exp 0/0", hi, lo); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags: busy=%b done=%b exp 0/0", busy, done); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op[7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd2};
        logic [31:0] t_a[7]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'h80000000, 32'd7, 32'hFFFFFFF9};
        logic [31:0] t_b[7]  = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] t_h[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'h0, 32'd7, 32'hFFFFFFF9};
        logic [31:0] t_l[7]  = '{32'hFFFFFFF1, 32'h00000001, 32'h0, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int cyc; bit moved, bok;
        for (int i = 0; i < 7; i++) begin
            start_op(t_op[i], t_a[i], t_b[i]);
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy_rise: got %b exp 1", i, busy); end
            wait_done(cyc, moved, bok);
            n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL dir%0d_latency: got %0d exp 33", i, cyc); end
            n_vec++; if (moved || !bok) begin n_err++; $display("FAIL dir%0d_calc_window: moved=%b busy_ok=%b exp 0/1", i, moved, bok); end
            n_vec++; if (hi !== t_h[i] || lo !== t_l[i]) begin n_err++; $display("FAIL dir%0d_result: got %h/%h exp %h/%h", i, hi, lo, t_h[i], t_l[i]); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_fall: got %b exp 0", i, busy); end
            @(posedge clk);
            #1;
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width: got %b exp 0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] a, b, eh, el;
        logic [1:0]  o;
        int cyc; bit moved, bok;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 31);
            model(o, a, b, eh, el);
            start_op(o, a, b);
            wait_done(cyc, moved, bok);
            n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL rnd%0d_latency: got %0d exp 33", i, cyc); end
            n_vec++; if (hi !== eh || lo !== el) begin n_err++; $display("FAIL rnd%0d_op%0d a=%h b=%h: got %h/%h exp %h/%h", i, o, a, b, hi, lo, eh, el); end
        end
    endtask

    task automatic test_busy_window();
        logic [31:0] h0, l0;
        int cyc; bit moved, bok;
        start_op(2'd1, 32'd100, 32'd3);
        repeat (10) @(posedge clk);
        h0 = hi; l0 = lo;
        @(negedge clk);
        start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd9; hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0;
        n_vec++; if (hi !== h0 || lo !== l0) begin n_err++; $display("FAIL busy_write_dropped: got %h/%h exp %h/%h", hi, lo, h0, l0); end
        wait_done(cyc, moved, bok);
        n_vec++; if (cyc !== 22) begin n_err++; $display("FAIL busy_restart_ignored: got %0d cycles exp 22", cyc); end
        n_vec++; if (hi !== 32'd0 || lo !== 32'd300) begin n_err++; $display("FAIL busy_first_op: got %h/%h exp 0/12c", hi, lo); end
        // In the done cycle: start with simultaneous writes, start must win.
        @(negedge clk);
        start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd3; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_vec++; if (hi !== 32'd0 || lo !== 32'd300) begin n_err++; $display("FAIL start_wins: got %h/%h exp 0/12c", hi, lo); end
        wait_done(cyc, moved, bok);
        n_vec++; if (hi !== 32'd0 || lo !== 32'd6) begin n_err++; $display("FAIL start_wins_op: got %h/%h exp 0/6", hi, lo); end
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA;
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        n_vec++; if (hi !== 32'hAA || lo !== 32'hAA) begin n_err++; $display("FAIL direct_both: got %h/%h exp aa/aa", hi, lo); end
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h77;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        n_vec++; if (hi !== 32'h77 || lo !== 32'hAA) begin n_err++; $display("FAIL direct_hi_only: got %h/%h exp 77/aa", hi, lo); end
    endtask

    task automatic test_reset_mid();
        start_op(2'd1, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL midrst_hilo: got %h/%h exp 0/0", hi, lo); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_flags: busy=%b done=%b exp 0/0", busy, done); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL midrst_stays_idle: busy=%b done=%b st=%0d exp 0/0/0", busy, done, dbg_state); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit moved, bok;
        start_op(2'd1, 32'd6, 32'd7);
        wait_done(cyc, moved, bok);
        n_vec++; if (hi !== 32'd0 || lo !== 32'd42) begin n_err++; $display("FAIL b2b_first: got %h/%h exp 0/2a", hi, lo); end
        start_op(2'd0, 32'hFFFFFFFD, 32'd5);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: busy=%b exp 1", busy); end
        wait_done(cyc, moved, bok);
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d exp 33", cyc); end
        n_vec++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL b2b_second: got %h/%h exp ffffffff/fffffff1", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_window();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
